f2c_dma_writer: RTL
===================

Name: f2c_dma_writer

Overview:
- FPGA-to-CPU DMA write engine on the endpoint side of the pcie-dma app.
- Collects a 64-bit upstream stream into 128-byte chunks and writes each chunk to one slot of a 16-slot ring in host memory.
- After each chunk, publishes its write pointer with a one-QW write at base+16*128.
- Host software polls that pointer, consumes slots, and returns its read pointer through the F2C_RDPTR register. The register decoder supplies enable_in, base_in and rdPtr_in; the TLP transmitter consumes the tlp* port.

Parameters:
- QW_PER_TLP, 16, qwords per data TLP; payload is 128 bytes.
- LOG2_SLOTS, 4, log2 of the ring slot count; 16 slots.

Ports:
- clk_in  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- enable_in  in  1  DMA_ENABLE register bit.
- base_in  in  64  F2C_BASE host byte address; bits [6:0] are ignored (treated as 0).
- rdPtr_in  in  LOG2_SLOTS  F2C_RDPTR: next slot the host will read.
- data_in  in  64  upstream qword.
- valid_in  in  1  upstream data valid.
- ready_out  out  1  block accepts data_in this cycle.
- tlpValid_out  out  1  beat valid toward the TLP transmitter.
- tlpReady_in  in  1  transmitter accepts the beat.
- tlpAddr_out  out  64  host byte address of the current TLP; stable for all beats of that TLP.
- tlpQwCount_out  out  5  16 for a data TLP, 1 for a pointer TLP; stable for all beats.
- tlpData_out  out  64  beat payload.
- tlpFirst_out  out  1  first beat of a TLP.
- tlpLast_out  out  1  last beat of a TLP.
- wrPtr_out  out  LOG2_SLOTS  current slot write pointer, for status readback.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; wrPtr=0; fill count=0.
  - ready_out=0, tlpValid_out=0, tlpFirst_out=0, tlpLast_out=0.
  - tlpAddr_out=0, tlpQwCount_out=0, tlpData_out=0, wrPtr_out=0.
  - Reset mid-TLP abandons the TLP immediately; no further beats are emitted.
- Buffer: 16x64 registers plus a 5-bit fill count. A beat transfers when valid_in & ready_out (upstream) or tlpValid_out & tlpReady_in (downstream).
- IDLE:
  - ready_out=0; wrPtr forced to 0.
  - Fill count and buffer contents are retained.
  - enable_in=1 -> FILL.
- FILL:
  - ready_out=1 while count<16. Each accepted qword is written to buf[count], then count increments.
  - When count reaches 16 -> WAIT_SLOT; ready_out=0 from the next cycle.
  - enable_in=0 while in FILL -> IDLE.
- WAIT_SLOT:
  - Ring is full when ((wrPtr+1) mod 16) == rdPtr_in. This one-empty-slot rule gives at most 15 outstanding slots.
  - Not full -> SEND_DATA and latch tlpAddr = {base_in[63:7],7'b0} + wrPtr*128, tlpQwCount=16.
  - enable_in=0 -> IDLE; the buffer stays full.
- SEND_DATA:
  - tlpValid_out=1 and tlpData_out=buf[beat] for beat 0..15.
  - tlpFirst_out on beat 0; tlpLast_out on beat 15.
  - Advance only on tlpReady_in; outputs hold while ready is low.
  - After beat 15 is accepted -> SEND_PTR, wrPtr <= wrPtr+1 (mod 16), count <= 0.
  - enable_in is ignored once SEND_DATA is entered.
- SEND_PTR:
  - One beat: tlpAddr_out = {base_in[63:7],7'b0} + 16*128.
  - tlpQwCount_out=1; tlpData_out = zero-extended updated wrPtr; tlpFirst_out=tlpLast_out=1.
  - On accept -> FILL if enable_in=1, else IDLE.
- Ordering: the pointer write always directly follows its data TLP with no gap state, so the host never sees a pointer ahead of its data.
- rdPtr_in is sampled every cycle in WAIT_SLOT; a change takes effect on the next cycle.
- Address arithmetic: 64-bit, with slot index confined to LOG2_SLOTS bits. The pointer qword sits just past slot 15.
- wrPtr_out = internal wrPtr at all times.
- Throughput: at most one upstream or one downstream beat per cycle. No fill overlaps a send.

Test Plan:
- Post-reset values: assert rstn=0, then release with enable_in=0 -> all outputs 0 and ready_out=0 indefinitely.
- Basic chunk:
  - Stimulus: base_in=0, enable_in=1, rdPtr_in=0, tlpReady_in=1; feed 16 qwords 0x0..0xF.
  - Data TLP: 16 beats at addr 0x0, count 16, data in order, first/last flags on beats 0/15.
  - Pointer TLP: next beat at addr 0x800, data 0x1, first=last=1; then wrPtr_out=1.
- Backpressure: toggle tlpReady_in randomly -> data order intact, tlpAddr_out/tlpData_out stable while ready is low, no beat dropped or repeated.
- Ring full and wrap:
  - Hold rdPtr_in=0 and feed 16 chunks -> exactly 15 data TLPs, at slots 0..14 (addr base+0..base+0x700); 16th chunk waits in WAIT_SLOT.
  - Set rdPtr_in=1 -> 16th chunk goes to slot 15, pointer data 0x0 (wrap).
- Base masking: base_in=0x1_0000_0047 -> first data TLP at 0x1_0000_0000, pointer write at 0x1_0000_0800.
- Enable mid-operation:
  - Drop enable_in after 5 qwords accepted -> IDLE, ready_out=0, wrPtr_out=0.
  - Re-enable and feed 11 more -> TLP contains all 16 qwords in order.
  - Drop enable_in during SEND_DATA -> TLP and its pointer write complete, then IDLE.

Source files
------------

// File: rtl/f2c_dma_writer.sv
// Purpose: FPGA-to-CPU DMA writer; packs 16 upstream qwords into one 128-byte slot write, then a 1-QW write-pointer update.
// Latency: a chunk is sent once all 16 qwords are buffered and a ring slot is free; the pointer beat directly follows data beat 15.
// Backpressure: ready_out is high only while filling; TLP beats advance only on tlpReady_in, and outputs hold while it is low.
//
// Ports:
//   clk_in, rstn                  clock, async active-low reset
//   enable_in, base_in, rdPtr_in  register decoder: DMA enable, ring base address, host read pointer
//   data_in, valid_in, ready_out  upstream qword stream
//   tlp*                          beat interface toward the TLP transmitter
//   wrPtr_out                     current slot write pointer (status)
module f2c_dma_writer #(
    parameter int QW_PER_TLP = 16,
    parameter int LOG2_SLOTS = 4
) (
    input  logic                  clk_in,
    input  logic                  rstn,
    input  logic                  enable_in,
    input  logic [63:0]           base_in,
    input  logic [LOG2_SLOTS-1:0] rdPtr_in,
    input  logic [63:0]           data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  tlpValid_out,
    input  logic                  tlpReady_in,
    output logic [63:0]           tlpAddr_out,
    output logic [4:0]            tlpQwCount_out,
    output logic [63:0]           tlpData_out,
    output logic                  tlpFirst_out,
    output logic                  tlpLast_out,
    output logic [LOG2_SLOTS-1:0] wrPtr_out
);

    localparam int BW       = $clog2(QW_PER_TLP);
    localparam int CW       = BW + 1;
    localparam int TLP_LOG2 = $clog2(QW_PER_TLP * 8);

    // Slot addresses are aligned to the payload size; low base bits are dropped.
    localparam logic [63:0] ADDR_MASK = ~64'(QW_PER_TLP * 8 - 1);
    // The pointer qword lives just past the last slot.
    localparam logic [63:0] PTR_OFF   = 64'((1 << LOG2_SLOTS) * QW_PER_TLP * 8);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FILL = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_PTR  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [LOG2_SLOTS-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [63:0]           addr_q, addr_d;
    logic [4:0]            qwc_q, qwc_d;
    logic [63:0]           qbuf_q [QW_PER_TLP];
    logic [63:0]           qbuf_d [QW_PER_TLP];

    logic                  up_xfer;
    logic                  dn_xfer;
    logic [LOG2_SLOTS-1:0] wr_ptr_inc;
    logic [63:0]           base_al;

    assign ready_out      = (state_q == ST_FILL) && (count_q < CW'(QW_PER_TLP));
    assign tlpValid_out   = (state_q == ST_DATA) || (state_q == ST_PTR);
    assign tlpFirst_out   = ((state_q == ST_DATA) && (beat_q == '0)) || (state_q == ST_PTR);
    assign tlpLast_out    = ((state_q == ST_DATA) && (beat_q == BW'(QW_PER_TLP - 1))) || (state_q == ST_PTR);
    assign tlpAddr_out    = addr_q;
    assign tlpQwCount_out = qwc_q;
    assign wrPtr_out      = wr_ptr_q;

    always_comb begin
        tlpData_out = '0;
        if (state_q == ST_DATA) begin
            tlpData_out = qbuf_q[beat_q];
        end else if (state_q == ST_PTR) begin
            // wr_ptr_q has already advanced past the slot just written.
            tlpData_out = 64'(wr_ptr_q);
        end
    end

    always_comb begin
        up_xfer    = valid_in && ready_out;
        dn_xfer    = tlpValid_out && tlpReady_in;
        wr_ptr_inc = wr_ptr_q + LOG2_SLOTS'(1);
        base_al    = base_in & ADDR_MASK;

        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        qwc_d    = qwc_q;
        qbuf_d   = qbuf_q;

        case (state_q)
            ST_IDLE: begin
                wr_ptr_d = '0;
                if (enable_in) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (up_xfer) begin
                    qbuf_d[count_q[BW-1:0]] = data_in;
                    count_d = count_q + CW'(1);
                end
                // A buffer left full by an earlier disable drops straight to WAIT.
                if (!enable_in) begin
                    state_d = ST_IDLE;
                end else if (count_d == CW'(QW_PER_TLP)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // One slot is always left empty so full and empty stay distinguishable.
                if (!enable_in) begin
                    state_d = ST_IDLE;
                end else if (wr_ptr_inc != rdPtr_in) begin
                    state_d = ST_DATA;
                    addr_d  = base_al + (64'(wr_ptr_q) << TLP_LOG2);
                    qwc_d   = 5'(QW_PER_TLP);
                    beat_d  = '0;
                end
            end
            ST_DATA: begin
                if (dn_xfer) begin
                    if (beat_q == BW'(QW_PER_TLP - 1)) begin
                        state_d  = ST_PTR;
                        wr_ptr_d = wr_ptr_inc;
                        count_d  = '0;
                        addr_d   = base_al + PTR_OFF;
                        qwc_d    = 5'd1;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            ST_PTR: begin
                if (dn_xfer) begin
                    state_d = enable_in ? ST_FILL : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            addr_q   <= '0;
            qwc_q    <= '0;
            for (int i = 0; i < QW_PER_TLP; i++) begin
                qbuf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            qwc_q    <= qwc_d;
            qbuf_q   <= qbuf_d;
        end
    end

endmodule
